ps2_mouse_ctrl: RTL



---
 rtl/ps2_mouse_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse init sequencer (ACK checks, timeouts, bounded retries) and 3-byte packet assembler.
// Define MOUSE_POS_ACCUM_EN to build the clamped cursor position accumulator.
module ps2_mouse_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          SKIP_INIT      = 1'b0,
  parameter int unsigned X_MAX          = 639,
  parameter int unsigned Y_MAX          = 479
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  input  logic       tx_idle,
  input  logic       tx_done_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       init_done,
  output logic       init_error,
  output logic       pkt_valid,
  output logic [8:0] pkt_dx,
  output logic [8:0] pkt_dy,
  output logic [2:0] pkt_btn,
  output logic [1:0] pkt_ovf,
  output logic [7:0] sync_err_cnt,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 2);

  localparam logic [3:0] S_TX_RST    = 4'd0;
  localparam logic [3:0] S_ACK_RST   = 4'd1;
  localparam logic [3:0] S_BAT       = 4'd2;
  localparam logic [3:0] S_ID        = 4'd3;
  localparam logic [3:0] S_TX_EN     = 4'd4;
  localparam logic [3:0] S_ACK_EN    = 4'd5;
  localparam logic [3:0] S_STREAM_B0 = 4'd6;
  localparam logic [3:0] S_STREAM_B1 = 4'd7;
  localparam logic [3:0] S_STREAM_B2 = 4'd8;
  localparam logic [3:0] S_ERROR     = 4'd9;

  logic [3:0]    state_q, state_d, next_st, prev_tx, retry_tgt;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          sent_q, sent_d;
  logic [6:0]    hdr_q, hdr_d;  // {ovf[1:0], ysign, xsign, btn[2:0]} of byte 0
  logic [7:0]    b1_q, b1_d, exp_byte, tx_data_d, sync_d;
  logic          tx_wr_d, init_error_d, pkt_valid_d, retry_req, reenter, expire, tmo_en, is_tx;
  logic [8:0]    pkt_dx_d, pkt_dy_d;
  logic [2:0]    pkt_btn_d;
  logic [1:0]    pkt_ovf_d;

  assign expire    = (tmo_q == TW'(TIMEOUT_CYCLES));
  assign tmo_en    = (state_q != S_STREAM_B0) && (state_q != S_ERROR);
  assign is_tx     = (state_q == S_TX_RST) || (state_q == S_TX_EN);
  assign init_done = (state_q == S_STREAM_B0) || (state_q == S_STREAM_B1) ||
                     (state_q == S_STREAM_B2);

  always_comb begin
    exp_byte = 8'hFA;
    next_st  = S_BAT;
    prev_tx  = S_TX_RST;
    case (state_q)
      S_BAT:    begin exp_byte = 8'hAA; next_st = S_ID;    end
      S_ID:     begin exp_byte = 8'h00; next_st = S_TX_EN; end
      S_ACK_EN: begin next_st = S_STREAM_B0; prev_tx = S_TX_EN; end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    hdr_d       = hdr_q;
    b1_d        = b1_q;
    sync_d      = sync_err_cnt;
    pkt_valid_d = 1'b0;
    pkt_dx_d    = pkt_dx;
    pkt_dy_d    = pkt_dy;
    pkt_btn_d   = pkt_btn;
    pkt_ovf_d   = pkt_ovf;
    retry_req   = 1'b0;
    retry_tgt   = S_TX_RST;
    case (state_q)
      S_TX_RST, S_TX_EN: begin
        if (sent_q && tx_done_tick) state_d = (state_q == S_TX_RST) ? S_ACK_RST : S_ACK_EN;
        else if (expire)            retry_req = 1'b1;
      end
      S_ACK_RST, S_BAT, S_ID, S_ACK_EN: begin
        if (rx_done_tick && rx_data == exp_byte) begin
          state_d = next_st;
          if (state_q == S_ACK_EN) retry_d = '0;
        end else if (rx_done_tick && rx_data == 8'hFE) begin
          retry_req = 1'b1;
          retry_tgt = prev_tx;
        end else if (expire) begin
          retry_req = 1'b1;
        end
      end
      S_STREAM_B0: begin
        if (rx_done_tick) begin
          if (rx_data[3]) begin
            hdr_d   = {rx_data[7:4], rx_data[2:0]};
            state_d = S_STREAM_B1;
          end else if (sync_err_cnt != 8'hFF) begin
            sync_d = sync_err_cnt + 8'd1;
          end
        end
      end
      S_STREAM_B1: begin
        if (rx_done_tick) begin
          b1_d    = rx_data;
          state_d = S_STREAM_B2;
        end else if (expire) begin
          state_d = S_STREAM_B0;
        end
      end
      S_STREAM_B2: begin
        if (rx_done_tick) begin
          pkt_dx_d    = {hdr_q[3], b1_q};
          pkt_dy_d    = {hdr_q[4], rx_data};
          pkt_btn_d   = hdr_q[2:0];
          pkt_ovf_d   = hdr_q[6:5];
          pkt_valid_d = 1'b1;
          state_d     = S_STREAM_B0;
        end else if (expire) begin
          state_d = S_STREAM_B0;
        end
      end
      S_ERROR: ;
      default: state_d = S_ERROR;
    endcase

    if (retry_req) begin
      if (retry_q == RW'(MAX_RETRIES)) begin
        state_d = S_ERROR;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = retry_tgt;
      end
    end

    // A retry into the same TX state still counts as a fresh entry.
    reenter      = retry_req || (state_d != state_q);
    tmo_d        = (reenter || !tmo_en) ? '0 : tmo_q + 1'b1;
    tx_wr_d      = is_tx && !sent_q && tx_idle && !reenter;
    sent_d       = !reenter && (sent_q || tx_wr_d);
    init_error_d = init_error || (state_d == S_ERROR);
    tx_data_d    = tx_data;
    if (state_d == S_TX_RST)     tx_data_d = 8'hFF;
    else if (state_d == S_TX_EN) tx_data_d = 8'hF4;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SKIP_INIT ? S_STREAM_B0 : S_TX_RST;
      retry_q      <= '0;
      tmo_q        <= '0;
      sent_q       <= 1'b0;
      hdr_q        <= '0;
      b1_q         <= '0;
      tx_wr        <= 1'b0;
      tx_data      <= '0;
      init_error   <= 1'b0;
      pkt_valid    <= 1'b0;
      pkt_dx       <= '0;
      pkt_dy       <= '0;
      pkt_btn      <= '0;
      pkt_ovf      <= '0;
      sync_err_cnt <= '0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      sent_q       <= sent_d;
      hdr_q        <= hdr_d;
      b1_q         <= b1_d;
      tx_wr        <= tx_wr_d;
      tx_data      <= tx_data_d;
      init_error   <= init_error_d;
      pkt_valid    <= pkt_valid_d;
      pkt_dx       <= pkt_dx_d;
      pkt_dy       <= pkt_dy_d;
      pkt_btn      <= pkt_btn_d;
      pkt_ovf      <= pkt_ovf_d;
      sync_err_cnt <= sync_d;
    end
  end

`ifdef MOUSE_POS_ACCUM_EN
  logic signed [11:0] sum_x, sum_y;

  function automatic logic [9:0] clamp(input logic signed [11:0] v, input logic [11:0] hi);
    if (v < 12'sd0)          return 10'd0;
    else if (v > $signed(hi)) return hi[9:0];
    else                     return v[9:0];
  endfunction

  // Screen Y grows downward while mouse dy is up-positive.
  assign sum_x = $signed({2'b00, pos_x}) + $signed({{3{pkt_dx[8]}}, pkt_dx});
  assign sum_y = $signed({2'b00, pos_y}) - $signed({{3{pkt_dy[8]}}, pkt_dy});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_x <= 10'd100;
      pos_y <= 10'd100;
    end else if (pkt_valid) begin
      if (!pkt_ovf[0]) pos_x <= clamp(sum_x, 12'(X_MAX));
      if (!pkt_ovf[1]) pos_y <= clamp(sum_y, 12'(Y_MAX));
    end
  end
`else
  logic [31:0] unused_pos_params;
  assign unused_pos_params = X_MAX ^ Y_MAX;
  assign pos_x = '0;
  assign pos_y = '0;
`endif

endmodule
